// File: rtl/fht_input_loader.sv
// Front-end loader for the FHT core: streams samples into the four data banks in
// bit-reversed order, starts fht_control once a frame is complete and waits for it to finish.
module fht_input_loader #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic             oSTART,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA_WR,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oBUSY,
    output logic [7:0]       oFRAME_CNT
);

    localparam int IW = A_BIT + 2;
    localparam logic [IW-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       we_q, we_d;
    logic [A_BIT-1:0] addr_q, addr_d;
    logic [D_BIT-1:0] data_q, data_d;
    logic [7:0]       frm_q, frm_d;
    logic [IW-1:0]    rev;

    function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        for (int i = 0; i < IW; i++) begin
            r[i] = v[IW-1-i];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        frm_d   = frm_q;
        rev     = bit_rev(idx_q);

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (iVALID) begin
                    // The top two reversed bits pick the bank, the rest is the in-bank address.
                    idx_d  = idx_q + IW'(1);
                    we_d   = 4'b0001 << rev[IW-1:A_BIT];
                    addr_d = rev[A_BIT-1:0];
                    data_d = iDATA;
                    if (idx_q == LAST_IDX) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: state_d = START;
            START: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!iFHT_RDY) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (iFHT_RDY) begin
                    frm_d   = frm_q + 8'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            frm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            frm_q   <= frm_d;
        end
    end

    assign oREADY     = (state_q == LOAD);
    assign oSTART     = (state_q == START);
    assign oBUSY      = (state_q == START) || (state_q == WAIT_ACK) || (state_q == WAIT_DONE);
    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oADDR_WR   = addr_q;
    assign oDATA_WR   = data_q;
    assign oFRAME_CNT = frm_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Bench for fht_input_loader with A_BIT=2 (16-point frames) and a simple fht_control model.
module tb_fht_input_loader;

    logic        iCLK, iRESET, iVALID, iFHT_RDY;
    logic [15:0] iDATA;
    logic        oREADY, oSTART, oBUSY;
    logic [1:0]  oADDR_WR;
    logic [15:0] oDATA_WR;
    logic        oWE_0, oWE_1, oWE_2, oWE_3;
    logic [7:0]  oFRAME_CNT;

    fht_input_loader #(.A_BIT(2), .D_BIT(16)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .iFHT_RDY(iFHT_RDY), .oSTART(oSTART), .oADDR_WR(oADDR_WR), .oDATA_WR(oDATA_WR),
        .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
        .oBUSY(oBUSY), .oFRAME_CNT(oFRAME_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [1:0]  bank;
        logic [1:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   start_cnt = 0;
    int   exp_starts = 0;
    int   exp_frames = 0;
    logic [3:0] m_idx = 4'd0;
    logic [3:0] mon_we;
    wr_t  mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

    always @(posedge iCLK) cyc <= cyc + 1;

    // Write monitor: every bank write must match the next queued expectation.
    always @(negedge iCLK) begin
        if (!iRESET) begin
            if (oSTART) start_cnt++;
            mon_we = {oWE_3, oWE_2, oWE_1, oWE_0};
            if (mon_we != 4'd0) begin
                wr_cnt++;
                if (wr_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                chk("we_onehot", $countones(mon_we), 1);
                if (exp_q.size() == 0) begin
                    chk("stray_wr", {28'd0, mon_we}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_bank", {28'd0, mon_we}, 32'd1 << mon_e.bank);
                    chk("wr_addr", {30'd0, oADDR_WR}, {30'd0, mon_e.addr});
                    chk("wr_data", {16'd0, oDATA_WR}, {16'd0, mon_e.data});
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] d);
        wr_t  e;
        logic [3:0] r;
        r = rev4(m_idx);
        e.bank = r[3:2];
        e.addr = r[1:0];
        e.data = d;
        exp_q.push_back(e);
        m_idx = m_idx + 4'd1;
        iVALID = 1'b1;
        iDATA  = d;
        @(posedge iCLK); #1;
    endtask

    task automatic send_frame(input bit gap, input bit hold, input int n, input logic [15:0] base);
        for (int t = 0; t < 50 && !oREADY; t++) begin
            @(posedge iCLK); #1;
        end
        chk("ready_wait", {31'd0, oREADY}, 1);
        for (int i = 0; i < n; i++) begin
            send_beat(base + 16'(i));
            if (gap && i < n - 1) begin
                iVALID = 1'b0;
                @(posedge iCLK); #1;
            end
        end
        if (!hold) iVALID = 1'b0;
    endtask

    // Entered just after the edge that accepted the last beat of a frame.
    task automatic after_frame(input int span, input int lo_wait, input int lo_len, input bit pre_low);
        @(negedge iCLK);
        chk("flush_ready", {31'd0, oREADY}, 0);
        chk("flush_start", {31'd0, oSTART}, 0);
        chk("flush_busy", {31'd0, oBUSY}, 0);
        @(negedge iCLK);
        chk("start_pulse", {31'd0, oSTART}, 1);
        chk("start_busy", {31'd0, oBUSY}, 1);
        chk("start_ready", {31'd0, oREADY}, 0);
        chk("wr_count", wr_cnt, 16);
        chk("wr_span", last_cyc - first_cyc, span);
        exp_starts++;
        repeat (lo_wait) begin
            @(posedge iCLK); #2;
            chk("busy_ready", {31'd0, oREADY}, 0);
            chk("busy_flag", {31'd0, oBUSY}, 1);
            chk("busy_start", {31'd0, oSTART}, 0);
        end
        if (!pre_low) iFHT_RDY = 1'b0;
        repeat (lo_len) begin
            @(posedge iCLK); #2;
            chk("xf_ready", {31'd0, oREADY}, 0);
            chk("xf_busy", {31'd0, oBUSY}, 1);
            chk("xf_cnt", {24'd0, oFRAME_CNT}, exp_frames);
        end
        iFHT_RDY = 1'b1;
        exp_frames = (exp_frames + 1) % 256;
        @(posedge iCLK); #2;
        chk("done_ready", {31'd0, oREADY}, 1);
        chk("done_busy", {31'd0, oBUSY}, 0);
        chk("done_cnt", {24'd0, oFRAME_CNT}, exp_frames);
        iVALID = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, oREADY}, 0);
        chk({tag, "_start"}, {31'd0, oSTART}, 0);
        chk({tag, "_we"}, {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, 0);
        chk({tag, "_addr"}, {30'd0, oADDR_WR}, 0);
        chk({tag, "_data"}, {16'd0, oDATA_WR}, 0);
        chk({tag, "_busy"}, {31'd0, oBUSY}, 0);
        chk({tag, "_cnt"}, {24'd0, oFRAME_CNT}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        iRESET = 1'b0; iVALID = 1'b0; iDATA = 16'd0; iFHT_RDY = 1'b1;
        #1 iRESET = 1'b1;
        #2 chk_all_zero("por");
        @(posedge iCLK); @(posedge iCLK); #1;
        iRESET = 1'b0;
        #1 chk("idle_ready", {31'd0, oREADY}, 0);
        @(posedge iCLK); #2;
        chk("load_ready", {31'd0, oREADY}, 1);

        // Back-to-back frame of samples 0..15, iVALID left high during the transform.
        wr_cnt = 0;
        send_frame(1'b0, 1'b1, 16, 16'd0);
        after_frame(15, 3, 20, 1'b0);

        // Same frame pattern with iVALID toggling.
        wr_cnt = 0; m_idx = 4'd0;
        send_frame(1'b1, 1'b0, 16, 16'd0);
        after_frame(30, 3, 20, 1'b0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send_beat(16'h0100 + 16'(i));
        @(negedge iCLK); #1;
        iRESET = 1'b1;
        #1 chk_all_zero("rst");
        iVALID = 1'b0; m_idx = 4'd0; exp_frames = 0;
        @(posedge iCLK); #1;
        iRESET = 1'b0;
        #1 chk("rst_idle", {31'd0, oREADY}, 0);
        @(posedge iCLK); #2;
        chk("rst_ready", {31'd0, oREADY}, 1);
        wr_cnt = 0;
        send_beat(16'hBEEF);
        @(negedge iCLK); #1;
        chk("rst_we0", {31'd0, oWE_0}, 1);
        chk("rst_addr0", {30'd0, oADDR_WR}, 0);
        send_frame(1'b0, 1'b0, 15, 16'h0200);
        after_frame(15, 3, 5, 1'b0);

        // 256 frames from a cleared counter; it must wrap back to zero.
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        #1 chk("wrap_clr", {24'd0, oFRAME_CNT}, 0);
        exp_frames = 0; m_idx = 4'd0;
        @(posedge iCLK); #1;
        iRESET = 1'b0;
        @(posedge iCLK); #2;
        for (int f = 0; f < 256; f++) begin
            wr_cnt = 0;
            send_frame(1'b0, 1'b0, 16, 16'($urandom));
            after_frame(15, 1, 2, 1'b0);
        end
        chk("wrap_zero", {24'd0, oFRAME_CNT}, 0);

        // fht_control already busy when WAIT_ACK is entered.
        iFHT_RDY = 1'b0;
        wr_cnt = 0;
        send_frame(1'b0, 1'b0, 16, 16'h3000);
        after_frame(15, 2, 8, 1'b1);
        iFHT_RDY = 1'b0;
        wr_cnt = 0;
        send_frame(1'b0, 1'b0, 16, 16'h4000);
        after_frame(15, 2, 0, 1'b1);

        repeat (4) @(posedge iCLK);
        #2 chk("start_total", start_cnt, exp_starts);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
